shift_seq_ctrl: RTL

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 76 +++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - parallel-to-serial frame controller, MSB first, variable length
module shift_seq_ctrl #(
  parameter  int WIDTH = 8,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] eff_len;
  logic [LEN_W-1:0] shamt;

  always_comb begin
    eff_len = in_len;
    if (in_len == '0 || in_len > WIDTH_L) eff_len = WIDTH_L;
    // Left-align the frame so its first bit sits at the MSB of sreg.
    shamt   = WIDTH_L - eff_len;
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
          sreg_d  = in_data << shamt;
          cnt_d   = eff_len;
        end
      end
      S_SHIFT: begin
        if (!hold) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst so the whole interface is quiet during reset.
  assign in_ready = (state_q == S_IDLE) & ~rst;
  assign ser_en   = (state_q == S_SHIFT) & ~hold & ~rst;
  assign ser_out  = ser_en & sreg_q[WIDTH-1];
  assign busy     = ((state_q == S_SHIFT) | (state_q == S_DONE)) & ~rst;
  assign done     = (state_q == S_DONE) & ~rst;

endmodule
